icebreaker_alu: RTL and testbench
=================================

ICEBREAKER_ALU -- requirements
Module: icebreaker_alu

Interface
REQ-001 SHALL expose parameter PRESCALE, default 35, clock cycles per 1/8 UART bit (32.256 MHz clock gives 115200 baud).
REQ-002 SHALL expose parameter DATA_WIDTH, default 8, UART data bits per frame.
REQ-003 SHALL expose port clk, input, 1, the single clock.
REQ-004 SHALL expose port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL expose port rxd, input, 1, UART serial in, asynchronous to clk.
REQ-006 SHALL expose port txd, output, 1, UART serial out.

Function
REQ-007 UART framing SHALL be 8N1, LSB first, idle high, with bit period PRESCALE*8 clocks.
REQ-008 rxd SHALL pass through a 2-flop synchronizer before use.
REQ-009 The receiver SHALL sample each bit at mid-bit, and SHALL discard any byte whose stop bit samples 0 (frame error).
REQ-010 A packet SHALL be: opcode byte, reserved byte (ignored), LEN_LO, LEN_HI, then LEN-4 payload bytes; LEN is the total packet byte count, little-endian.
REQ-011 The parser FSM SHALL have states OPCODE, RSVD, LEN_LO, LEN_HI, PAYLOAD, RESPOND; each received byte advances the FSM by one state.
REQ-012 When LEN ≤ 4, the FSM SHALL go from LEN_HI directly to RESPOND for add/mul, and directly to OPCODE for echo or an unknown opcode.
REQ-013 Opcode 0xEC (echo): each payload byte SHALL be retransmitted unchanged, in order, with its start bit beginning ≤2 clocks after the byte is received.
REQ-014 Echo SHALL use a one-byte holding register; a byte received while the register is still full SHALL be dropped.
REQ-015 Opcode 0xA0 (add): payload SHALL be read as 32-bit little-endian operands, and the response SHALL be their sum modulo 2^32.
REQ-016 Opcode 0xA1 (mul): the response SHALL be the low 32 bits of the product of all operands.
REQ-017 The add/mul accumulator SHALL load the first operand and combine each later operand.
REQ-018 With zero operands, the add/mul result SHALL be 0x00000000.
REQ-019 For add/mul, trailing payload bytes (LEN-4 not a multiple of 4) SHALL be ignored.
REQ-020 The add/mul result SHALL be sent as 4 bytes, LSB first; the first start bit SHALL begin ≤2 clocks after the final payload byte, and the 4 bytes SHALL be sent back-to-back.
REQ-021 The FSM SHALL return to OPCODE after the last result byte is sent.
REQ-022 Bytes arriving during RESPOND SHALL be dropped.
REQ-023 Any other opcode SHALL have its LEN-4 payload bytes consumed with no response.
REQ-024 The 16-bit LEN SHALL be handled up to 65535; the internal byte counter SHALL NOT wrap before LEN is reached.

Reset
REQ-025 While rst=1 at a clk edge: txd=1, FSM=OPCODE, accumulator=0, byte counter=0, holding register empty, and RX/TX engines idle.
REQ-026 A reset asserted mid-packet or mid-transmission SHALL abort it; txd SHALL be high on the next clock, and the partial packet SHALL be discarded.
REQ-027 The first packet after reset SHALL be parsed from its opcode byte.

Configuration
REQ-028 Macro ICEBREAKER_ALU_MUL_EN defined: opcode 0xA1 SHALL be implemented per REQ-016.
REQ-029 Macro ICEBREAKER_ALU_MUL_EN undefined: no multiplier SHALL be synthesized, and 0xA1 SHALL be handled as an unknown opcode (REQ-023).

Structure
REQ-030 Package icebreaker_alu_pkg SHALL hold the opcode enum (OP_ECHO=0xEC, OP_ADD=0xA0, OP_MUL=0xA1), the FSM state enum, HEADER_BYTES=4 and PRESCALE_DEFAULT=35.
REQ-031 Sub-module icebreaker_alu_uart SHALL hold the RX and TX engines.
REQ-032 icebreaker_alu_uart SHALL expose valid/ready byte streams (s_tdata/s_tvalid/s_tready, m_tdata/m_tvalid/m_tready) plus tx_busy, rx_busy and rx_frame_error.
REQ-033 The parser/ALU SHALL live in icebreaker_alu.

Verification
REQ-034 Echo: EC 00 07 00 41 42 43 -> txd emits 41 42 43.
REQ-035 Add: A0 00 0C 00 01 00 00 00 02 00 00 00 -> 03 00 00 00.
REQ-036 Add wrap: A0 00 0C 00 FF FF FF FF 02 00 00 00 -> 01 00 00 00.
REQ-037 Mul: A1 00 0C 00 03 00 00 00 05 00 00 00 -> 0F 00 00 00 with ICEBREAKER_ALU_MUL_EN defined; no txd activity without it.
REQ-038 Unknown opcode then echo: 55 00 06 00 AA BB, then EC 00 05 00 5A -> only 5A emitted.
REQ-039 Reset mid-packet: send A0 00 0C 00 01, pulse rst, then the full add packet of REQ-035 -> only 03 00 00 00 emitted, and txd=1 during reset.

Source files
------------

// File: rtl/icebreaker_alu_pkg.sv
// icebreaker_alu_pkg: shared opcodes, parser/UART state encodings and sizes.
// No ports; imported by icebreaker_alu and icebreaker_alu_uart.
package icebreaker_alu_pkg;

   localparam int HEADER_BYTES     = 4;
   localparam int PRESCALE_DEFAULT = 35;

   typedef enum logic [7:0] {
      OP_ADD  = 8'hA0,
      OP_MUL  = 8'hA1,
      OP_ECHO = 8'hEC
   } opcode_e;

   typedef enum logic [2:0] {
      ST_OPCODE,
      ST_RSVD,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_PAYLOAD,
      ST_RESPOND
   } state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/icebreaker_alu_uart.sv
// icebreaker_alu_uart: 8N1 UART RX/TX engines, bit period PRESCALE*8 clocks.
// Ports: clk, rst (sync, active-high), rxd/txd serial lines,
//   s_t* byte stream in (to TX), m_t* byte stream out (from RX),
//   tx_busy, rx_busy, rx_frame_error (one-cycle pulse on bad stop bit).
module icebreaker_alu_uart
   import icebreaker_alu_pkg::*;
#(
   parameter int PRESCALE   = PRESCALE_DEFAULT,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   output logic                  txd,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  tx_busy,
   output logic                  rx_busy,
   output logic                  rx_frame_error
);

   localparam int BIT = PRESCALE * 8;
   localparam int CW  = $clog2(BIT);
   localparam int NW  = $clog2(DATA_WIDTH + 2);
   localparam logic [CW-1:0] BIT_M1  = CW'(BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(BIT / 2 - 1);

   logic [1:0]            sync_q;
   rx_state_e             rx_st_q, rx_st_d;
   logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
   logic [NW-1:0]         rx_bit_q, rx_bit_d;
   logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
   logic                  m_tvalid_q, m_tvalid_d;
   logic                  rx_ferr_q, rx_ferr_d;
   logic                  rxs, rx_tick;

   logic                  tx_busy_q, tx_busy_d;
   logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
   logic [NW-1:0]         tx_bit_q, tx_bit_d;
   logic [DATA_WIDTH:0]   tx_sh_q, tx_sh_d;
   logic                  txd_q, txd_d;
   logic                  tx_end;

   assign rxs     = sync_q[1];
   assign rx_tick = (rx_cnt_q == '0);

   always_comb begin
      rx_st_d    = rx_st_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q && !m_tready;
      rx_ferr_d  = 1'b0;
      if (!rx_tick) rx_cnt_d = rx_cnt_q - 1'b1;
      unique case (rx_st_q)
         RX_IDLE: begin
            if (!rxs) begin
               rx_st_d  = RX_START;
               rx_cnt_d = HALF_M1;
            end
         end
         RX_START: begin
            // Mid start bit: a glitch that went high again is ignored.
            if (rx_tick) begin
               if (rxs) begin
                  rx_st_d = RX_IDLE;
               end else begin
                  rx_st_d  = RX_DATA;
                  rx_cnt_d = BIT_M1;
                  rx_bit_d = '0;
               end
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_sh_d  = {rxs, rx_sh_q[DATA_WIDTH-1:1]};
               rx_cnt_d = BIT_M1;
               if (rx_bit_q == NW'(DATA_WIDTH - 1)) rx_st_d = RX_STOP;
               else rx_bit_d = rx_bit_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               if (rxs) begin
                  m_tdata_d  = rx_sh_q;
                  m_tvalid_d = 1'b1;
                  rx_st_d    = RX_IDLE;
               end else begin
                  rx_ferr_d = 1'b1;
                  rx_st_d   = RX_WAIT_HIGH;
               end
            end
         end
         RX_WAIT_HIGH: begin
            // A low stop bit must not be taken as the next start bit.
            if (rxs) rx_st_d = RX_IDLE;
         end
         default: rx_st_d = RX_IDLE;
      endcase
   end

   assign tx_end   = tx_busy_q && (tx_cnt_q == '0) && (tx_bit_q == '0);
   // Accepting on the last stop-bit clock keeps bytes back-to-back.
   assign s_tready = !tx_busy_q || tx_end;

   always_comb begin
      tx_busy_d = tx_busy_q;
      tx_cnt_d  = tx_cnt_q;
      tx_bit_d  = tx_bit_q;
      tx_sh_d   = tx_sh_q;
      txd_d     = txd_q;
      if (tx_busy_q) begin
         if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - 1'b1;
         end else if (tx_bit_q != '0) begin
            txd_d    = tx_sh_q[0];
            tx_sh_d  = {1'b1, tx_sh_q[DATA_WIDTH:1]};
            tx_cnt_d = BIT_M1;
            tx_bit_d = tx_bit_q - 1'b1;
         end else begin
            tx_busy_d = 1'b0;
         end
      end
      if (s_tvalid && s_tready) begin
         tx_busy_d = 1'b1;
         txd_d     = 1'b0;
         tx_sh_d   = {1'b1, s_tdata};
         tx_cnt_d  = BIT_M1;
         tx_bit_d  = NW'(DATA_WIDTH + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= 2'b11;
         rx_st_q    <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '1;
         txd_q      <= 1'b1;
      end else begin
         sync_q     <= {sync_q[0], rxd};
         rx_st_q    <= rx_st_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         rx_ferr_q  <= rx_ferr_d;
         tx_busy_q  <= tx_busy_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         txd_q      <= txd_d;
      end
   end

   assign txd            = txd_q;
   assign m_tdata        = m_tdata_q;
   assign m_tvalid       = m_tvalid_q;
   assign tx_busy        = tx_busy_q;
   assign rx_busy        = (rx_st_q != RX_IDLE);
   assign rx_frame_error = rx_ferr_q;

endmodule

// File: rtl/icebreaker_alu.sv
// icebreaker_alu: UART packet parser with echo / 32-bit add / optional mul.
// Ports: clk, rst (sync, active-high), rxd (async serial in), txd.
// Macro ICEBREAKER_ALU_MUL_EN enables opcode 0xA1 (multiply).
module icebreaker_alu
   import icebreaker_alu_pkg::*;
#(
   parameter int PRESCALE   = PRESCALE_DEFAULT,
   parameter int DATA_WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic rxd,
   output logic txd
);

   logic [DATA_WIDTH-1:0] rx_tdata, tx_tdata;
   logic                  rx_tvalid, tx_tvalid, tx_tready;
   logic                  tx_busy;
   logic                  unused_rx_busy, unused_rx_ferr;
   logic [7:0]            rx_byte, tx_byte;

   icebreaker_alu_uart #(
      .PRESCALE  (PRESCALE),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_uart (
      .clk           (clk),
      .rst           (rst),
      .rxd           (rxd),
      .txd           (txd),
      .s_tdata       (tx_tdata),
      .s_tvalid      (tx_tvalid),
      .s_tready      (tx_tready),
      .m_tdata       (rx_tdata),
      .m_tvalid      (rx_tvalid),
      .m_tready      (1'b1),
      .tx_busy       (tx_busy),
      .rx_busy       (unused_rx_busy),
      .rx_frame_error(unused_rx_ferr)
   );

   state_e      st_q, st_d;
   logic [7:0]  op_q, op_d;
   logic [7:0]  len_lo_q, len_lo_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;
   logic [23:0] word_q, word_d;
   logic        have_q, have_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_v_q, hold_v_d;
   logic [2:0]  idx_q, idx_d;

   logic        arith, is_echo, last;
   logic [15:0] cnt_nx;
   logic [31:0] opnd, comb_val;

   assign rx_byte = 8'(rx_tdata);
   assign is_echo = (op_q == OP_ECHO);
   assign cnt_nx  = cnt_q + 16'd1;
   assign last    = (cnt_nx == len_q);
   assign opnd    = {rx_byte, word_q};

`ifdef ICEBREAKER_ALU_MUL_EN
   assign arith    = (op_q == OP_ADD) || (op_q == OP_MUL);
   assign comb_val = (op_q == OP_MUL) ? acc_q * opnd : acc_q + opnd;
`else
   assign arith    = (op_q == OP_ADD);
   assign comb_val = acc_q + opnd;
`endif

   // Echo data has priority; it never overlaps a result in practice.
   assign tx_tvalid = hold_v_q || ((st_q == ST_RESPOND) && !idx_q[2]);
   assign tx_byte   = hold_v_q ? hold_q : acc_q[{idx_q[1:0], 3'b000} +: 8];
   assign tx_tdata  = DATA_WIDTH'(tx_byte);

   always_comb begin
      st_d     = st_q;
      op_d     = op_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      word_d   = word_q;
      have_d   = have_q;
      hold_d   = hold_q;
      hold_v_d = hold_v_q;
      idx_d    = idx_q;
      if (tx_tvalid && tx_tready) begin
         if (hold_v_q) hold_v_d = 1'b0;
         else idx_d = idx_q + 3'd1;
      end
      unique case (st_q)
         ST_OPCODE: begin
            if (rx_tvalid) begin
               op_d   = rx_byte;
               cnt_d  = 16'd1;
               acc_d  = '0;
               have_d = 1'b0;
               idx_d  = '0;
               st_d   = ST_RSVD;
            end
         end
         ST_RSVD: begin
            if (rx_tvalid) begin
               cnt_d = 16'd2;
               st_d  = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (rx_tvalid) begin
               len_lo_d = rx_byte;
               cnt_d    = 16'd3;
               st_d     = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (rx_tvalid) begin
               len_d = {rx_byte, len_lo_q};
               cnt_d = 16'(HEADER_BYTES);
               if ({rx_byte, len_lo_q} <= 16'(HEADER_BYTES))
                  st_d = arith ? ST_RESPOND : ST_OPCODE;
               else
                  st_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (rx_tvalid) begin
               cnt_d = cnt_nx;
               if (is_echo && !hold_v_q) begin
                  hold_d   = rx_byte;
                  hold_v_d = 1'b1;
               end
               if (arith) begin
                  word_d = {rx_byte, word_q[23:8]};
                  // Payload starts at byte 4, so low bits give word lane.
                  if (cnt_q[1:0] == 2'd3) begin
                     acc_d  = have_q ? comb_val : opnd;
                     have_d = 1'b1;
                  end
               end
               if (last) st_d = arith ? ST_RESPOND : ST_OPCODE;
            end
         end
         ST_RESPOND: begin
            // Hold off new packets until the last stop bit is out.
            if (idx_q[2] && !tx_busy) st_d = ST_OPCODE;
         end
         default: st_d = ST_OPCODE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= ST_OPCODE;
         op_q     <= '0;
         len_lo_q <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         word_q   <= '0;
         have_q   <= 1'b0;
         hold_q   <= '0;
         hold_v_q <= 1'b0;
         idx_q    <= '0;
      end else begin
         st_q     <= st_d;
         op_q     <= op_d;
         len_lo_q <= len_lo_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         word_q   <= word_d;
         have_q   <= have_d;
         hold_q   <= hold_d;
         hold_v_q <= hold_v_d;
         idx_q    <= idx_d;
      end
   end

endmodule

// File: tb/tb_icebreaker_alu.sv
// tb_icebreaker_alu: directed packets over rxd, txd decoded into a
// scoreboard and compared against expected response bytes.
module tb_icebreaker_alu;

   localparam int PS  = 2;
   localparam int BIT = PS * 8;
   localparam int BYTE_T = BIT * 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic txd;

   int total = 0;
   int bad   = 0;

   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   icebreaker_alu #(
      .PRESCALE  (PS),
      .DATA_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rxd(rxd),
      .txd(txd)
   );

   // txd decoder: {stop, data}; frames overlapped by reset are dropped.
   initial begin
      logic [7:0] b;
      logic       st;
      logic       hit;
      forever begin
         @(negedge txd);
         hit = 1'b0;
         for (int i = 0; i < BIT / 2; i++) begin
            @(negedge clk);
            if (rst) hit = 1'b1;
         end
         for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < BIT; i++) begin
               @(negedge clk);
               if (rst) hit = 1'b1;
            end
            b[k] = txd;
         end
         for (int i = 0; i < BIT; i++) begin
            @(negedge clk);
            if (rst) hit = 1'b1;
         end
         st = txd;
         if (!hit) got_q.push_back({st, b});
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      @(negedge clk);
      rxd = 1'b0;
      idle(BIT);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(BIT);
      end
      rxd = !bad_stop;
      idle(BIT);
      rxd = 1'b1;
      if (bad_stop) idle(2 * BIT);
   endtask

   // Bytes are taken from the low n bytes of v, first byte highest.
   task automatic send_pkt(input logic [127:0] v, input int n);
      for (int i = 0; i < n; i++)
         send_byte(v[8*(n-1-i) +: 8], 1'b0);
   endtask

   task automatic expect_bytes(input logic [127:0] v, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({1'b1, v[8*(n-1-i) +: 8]});
   endtask

   task automatic check(input string tag);
      logic [8:0] g, e;
      total++;
      assert (got_q.size() === exp_q.size()) else begin
         bad++;
         $error("FAIL %s count: got=%0d exp=%0d",
                tag, got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         total++;
         assert (g === e) else begin
            bad++;
            $error("FAIL %s byte: got=%h exp=%h", tag, g, e);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_txd_high(input string tag);
      total++;
      assert (txd === 1'b1) else begin
         bad++;
         $error("FAIL %s txd: got=%b exp=1", tag, txd);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle(5);
      check_txd_high("reset");
      rst = 1'b0;
      idle(4 * BIT);

      expect_bytes({8'h41, 8'h42, 8'h43}, 3);
      send_pkt({8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43}, 7);
      idle(4 * BYTE_T);
      check("echo");

      expect_bytes({8'h03, 8'h00, 8'h00, 8'h00}, 4);
      send_pkt({8'hA0, 8'h00, 8'h0C, 8'h00, 32'h01000000, 32'h02000000}, 12);
      idle(5 * BYTE_T);
      check("add");

      expect_bytes({8'h01, 8'h00, 8'h00, 8'h00}, 4);
      send_pkt({8'hA0, 8'h00, 8'h0C, 8'h00, 32'hFFFFFFFF, 32'h02000000}, 12);
      idle(5 * BYTE_T);
      check("add_wrap");

`ifdef ICEBREAKER_ALU_MUL_EN
      expect_bytes({8'h0F, 8'h00, 8'h00, 8'h00}, 4);
`endif
      send_pkt({8'hA1, 8'h00, 8'h0C, 8'h00, 32'h03000000, 32'h05000000}, 12);
      idle(5 * BYTE_T);
      check("mul");

      expect_bytes({8'h5A}, 1);
      send_pkt({8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB}, 6);
      send_pkt({8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A}, 5);
      idle(3 * BYTE_T);
      check("unknown_echo");

      expect_bytes({8'h00, 8'h00, 8'h00, 8'h00}, 4);
      send_pkt({8'hA0, 8'h00, 8'h04, 8'h00}, 4);
      idle(5 * BYTE_T);
      check("add_zero_ops");

      expect_bytes({8'h07, 8'h00, 8'h00, 8'h00}, 4);
      send_pkt({8'hEC, 8'h00, 8'h04, 8'h00}, 4);
      send_pkt({8'hA0, 8'h00, 8'h08, 8'h00, 32'h07000000}, 8);
      idle(5 * BYTE_T);
      check("short_echo_one_op");

      expect_bytes({8'h06, 8'h00, 8'h00, 8'h00}, 4);
      send_pkt({8'hA0, 8'h00, 8'h0E, 8'h00, 32'h01000000,
                32'h05000000, 8'hFF, 8'hFF}, 14);
      idle(5 * BYTE_T);
      check("add_trailing");

      expect_bytes({8'h58, 8'h59}, 2);
      send_pkt({8'hEC, 8'h00, 8'h06, 8'h00}, 4);
      send_byte(8'h33, 1'b1);
      send_pkt({8'h58, 8'h59}, 2);
      idle(3 * BYTE_T);
      check("frame_error");

      expect_bytes({8'h02, 8'h00, 8'h00, 8'h00, 8'h77}, 5);
      send_pkt({8'hA0, 8'h00, 8'h08, 8'h00, 32'h02000000}, 8);
      send_byte(8'h99, 1'b0);
      idle(5 * BYTE_T);
      send_pkt({8'hEC, 8'h00, 8'h05, 8'h00, 8'h77}, 5);
      idle(3 * BYTE_T);
      check("drop_in_respond");

      expect_bytes({8'h03, 8'h00, 8'h00, 8'h00}, 4);
      send_pkt({8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01}, 5);
      rst = 1'b1;
      idle(1);
      check_txd_high("rst_mid_pkt");
      idle(3);
      rst = 1'b0;
      idle(2 * BIT);
      send_pkt({8'hA0, 8'h00, 8'h0C, 8'h00, 32'h01000000, 32'h02000000}, 12);
      idle(5 * BYTE_T);
      check("rst_mid_pkt");

      send_pkt({8'hA0, 8'h00, 8'h08, 8'h00, 32'h09000000}, 8);
      idle(3 * BIT);
      rst = 1'b1;
      idle(1);
      check_txd_high("rst_mid_tx");
      idle(3);
      rst = 1'b0;
      idle(5 * BYTE_T);
      check("rst_mid_tx");

      expect_bytes({8'h21}, 1);
      send_pkt({8'hEC, 8'h00, 8'h05, 8'h00, 8'h21}, 5);
      idle(3 * BYTE_T);
      check("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
